// File: rtl/sfifo_param_if.sv
// Handshake/data bundle between a producer/consumer pair and sfifo_param.
// The master modport is the user side; the slave modport is the FIFO itself.
interface sfifo_param_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_BITS  = 4
);
  logic                  flush;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  write_n;
  logic                  read_n;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic [FIFO_BITS:0]    counter;

  modport master (
    output flush, data_in, write_n, read_n,
    input  data_out, full, empty, almost_full, almost_empty, overflow, underflow, counter
  );

  modport slave (
    input  flush, data_in, write_n, read_n,
    output data_out, full, empty, almost_full, almost_empty, overflow, underflow, counter
  );
endinterface

// File: rtl/sfifo_param.sv
// Single-clock FIFO with level flags, sticky overflow/underflow and sync flush; data_out 1 cycle after read,
// or head word shown combinationally when SFIFO_FWFT_EN is defined. Writes when full stall unless paired with a read.
module sfifo_param #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_BITS  = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4
) (
  input  logic         clock,
  input  logic         reset,
  sfifo_param_if.slave bus
);

  localparam logic [FIFO_BITS:0] CNT_FULL = (FIFO_BITS + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0] CNT_AF   = (FIFO_BITS + 1)'(AFULL_LVL);
  localparam logic [FIFO_BITS:0] CNT_AE   = (FIFO_BITS + 1)'(AEMPTY_LVL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic wr_req, rd_req, wr_ok, rd_ok, full, empty;

  assign wr_req = ~bus.write_n;
  assign rd_req = ~bus.read_n;
  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);

  // A write at full is still accepted when a read frees the slot in the same edge.
  assign wr_ok = wr_req & (~full | rd_req) & ~bus.flush;
  assign rd_ok = rd_req & ~empty & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (wr_req & full & ~rd_req) ovf_d = 1'b1;
      if (rd_req & empty)          udf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.data_in;
  end

`ifdef SFIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : mem[rd_ptr_q];
`else
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_ok) dout_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt_q >= CNT_AF);
  assign bus.almost_empty = (cnt_q <= CNT_AE);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.counter      = cnt_q;

endmodule

// File: tb/tb_sfifo_param.sv
// Scoreboard bench for sfifo_param: a queue model predicts occupancy, flags and read data;
// a monitor compares after every clock edge.
module tb_sfifo_param;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int B   = 4;
  localparam int AFL = 12;
  localparam int AEL = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sfifo_param_if #(.FIFO_WIDTH(W), .FIFO_BITS(B)) bus ();

  sfifo_param #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_BITS(B), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dout_m = '0;
  bit ovf_m = 1'b0;
  bit udf_m = 1'b0;
  bit fire  = 1'b0;
  bit fire_s;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input logic [W-1:0] d, input bit fl);
    bit is_full, is_empty, wr_ok, rd_ok;
    logic [W-1:0] v;
    bus.write_n = ~wr;
    bus.read_n  = ~rd;
    bus.data_in = d;
    bus.flush   = fl;
    fire = 1'b0;
    if (fl) begin
      mq.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end else begin
      is_full  = (mq.size() == D);
      is_empty = (mq.size() == 0);
      wr_ok = wr && (!is_full || rd);
      rd_ok = rd && !is_empty;
      if (wr && is_full && !rd) ovf_m = 1'b1;
      if (rd && is_empty)       udf_m = 1'b1;
      if (rd_ok) begin
        v = mq.pop_front();
`ifndef SFIFO_FWFT_EN
        exp_q.push_back(v);
        dout_m = v;
`endif
        fire = 1'b1;
      end
      if (wr_ok) mq.push_back(d);
    end
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    bus.write_n = 1'b1;
    bus.read_n  = 1'b1;
    bus.flush   = 1'b0;
    mq.delete();
    exp_q.delete();
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
    dout_m = '0;
    fire   = 1'b0;
    #1;
    chk("rst_count", int'(bus.counter), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_dout", int'(bus.data_out), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Monitor: evaluates the DUT just after each rising edge.
  always begin
    @(posedge clock);
    fire_s = fire;
    #1;
`ifdef SFIFO_FWFT_EN
    chk("fwft_head", int'(bus.data_out), (mq.size() != 0) ? int'(mq[0]) : 0);
`else
    if (fire_s) begin
      if (exp_q.size() == 0) chk("sb_underrun", exp_q.size(), 1);
      else chk("rd_data", int'(bus.data_out), int'(exp_q.pop_front()));
    end else begin
      chk("dout_hold", int'(bus.data_out), int'(dout_m));
    end
`endif
    chk("count", int'(bus.counter), mq.size());
    chk("full", int'(bus.full), int'(mq.size() == D));
    chk("empty", int'(bus.empty), int'(mq.size() == 0));
    chk("afull", int'(bus.almost_full), int'(mq.size() >= AFL));
    chk("aempty", int'(bus.almost_empty), int'(mq.size() <= AEL));
    chk("overflow", int'(bus.overflow), int'(ovf_m));
    chk("underflow", int'(bus.underflow), int'(udf_m));
  end

  initial begin
    bus.write_n = 1'b1;
    bus.read_n  = 1'b1;
    bus.flush   = 1'b0;
    bus.data_in = '0;
    @(negedge clock);
    pulse_reset();

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    pulse_reset();

    // Fill / drain
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Underflow with simultaneous read+write on empty
    step(1'b1, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Read+write at full, 0x77 emerges last
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Overflow: write 0xAA at full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Wrap: hold occupancy near 3 through 40 write/read pairs
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end

    // Flush with 3 words stored
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Head word on an empty FIFO
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Randomised phases biased toward filling, then draining
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 60; i++) begin
        int wp;
        wp = (p % 2 == 0) ? 80 : 25;
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (105 - wp),
             8'($urandom), $urandom_range(0, 199) == 0);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    pulse_reset();

    chk("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
